// File: rtl/rgb_pwm_capture_pkg.sv
// Shared constants and types for the RGB PWM duty/period capture block.
// CNT_W/CNT_MAX are the default counter width and its saturation value.
package rgb_pwm_capture_pkg;

    localparam int              CNT_W   = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } chan_state_e;

endpackage

// File: rtl/rgb_pwm_capture_chan.sv
// One PWM capture channel: synchronizer, rise detector and a two-state
// measurement FSM reporting high time and period in clk cycles.
module pwm_chan_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = rgb_pwm_capture_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] time_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o
);
    import rgb_pwm_capture_pkg::*;

    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   sync;
    logic                   rise;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] time_q, time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            sync_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~sync_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            per_q     <= '0;
            hi_q      <= '0;
            time_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            hi_q      <= hi_d;
            time_q    <= time_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        time_d    = time_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    per_d   = ONE;
                    hi_d    = ONE;
                end
            end
            MEASURE: begin
                // A rise on the saturating cycle still closes a normal period.
                if (rise) begin
                    time_d    = hi_q;
                    period_d  = per_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    per_d     = ONE;
                    hi_d      = ONE;
                end else if (per_q == SAT) begin
                    state_d   = IDLE;
                    time_d    = sync ? SAT : '0;
                    period_d  = '0;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    per_d = per_q + ONE;
                    if (sync && (hi_q != SAT)) begin
                        hi_d = hi_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign time_o    = time_q;
    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/rgb_pwm_capture.sv
// Three independent PWM capture channels; bit 2 = R, bit 1 = G, bit 0 = B.
module rgb_pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = rgb_pwm_capture_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             R_in,
    input  logic             G_in,
    input  logic             B_in,
    output logic [CNT_W-1:0] R_time_out,
    output logic [CNT_W-1:0] G_time_out,
    output logic [CNT_W-1:0] B_time_out,
    output logic [CNT_W-1:0] R_period_out,
    output logic [CNT_W-1:0] G_period_out,
    output logic [CNT_W-1:0] B_period_out,
    output logic [2:0]       valid_out,
    output logic [2:0]       timeout_out
);
    logic [2:0]       pwm_w;
    logic [CNT_W-1:0] time_w   [3];
    logic [CNT_W-1:0] period_w [3];

    assign pwm_w = {R_in, G_in, B_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            pwm_chan_capture #(
                .SYNC_STAGES(SYNC_STAGES),
                .CNT_W      (CNT_W)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst),
                .pwm_i    (pwm_w[gi]),
                .time_o   (time_w[gi]),
                .period_o (period_w[gi]),
                .valid_o  (valid_out[gi]),
                .timeout_o(timeout_out[gi])
            );
        end
    endgenerate

    assign R_time_out   = time_w[2];
    assign G_time_out   = time_w[1];
    assign B_time_out   = time_w[0];
    assign R_period_out = period_w[2];
    assign G_period_out = period_w[1];
    assign B_period_out = period_w[0];

endmodule
